// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cpu_pkg                                                     |
// | Shared widths, ALU opcode and operation encodings for the 16-bit CPU |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_ROL   = 4'b1010;
    localparam logic [3:0] OP_ROR   = 4'b1011;
    localparam logic [3:0] OP_PASSB = 4'b1111;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ex_stage_if                                                 |
// | ID/EX inputs and EX/MEM outputs of the execute stage                 |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface ex_stage_if;
    import cpu_pkg::*;

    logic [1:0]    alu_op;
    logic [3:0]    funct;
    logic          alu_src;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [RW-1:0] dest_reg;
    logic          mem_to_reg_in;
    logic          mem_write_in;
    logic          mem_read_in;
    logic          r15_in;
    logic          reg_write_in;
    logic          mov_op_in;
    logic          flush;

    logic [3:0]    operation;
    logic [DW-1:0] alu_result_out;
    logic [DW-1:0] alu_remainder_out;
    logic          overflow_out;
    logic [DW-1:0] store_data_out;
    logic [RW-1:0] dest_reg_out;
    logic          mem_to_reg_out;
    logic          mem_write_out;
    logic          mem_read_out;
    logic          r15_out;
    logic          reg_write_out;
    logic          mov_op_out;

    modport master (
        output alu_op, funct, alu_src, rd1, rd2, imm, dest_reg,
               mem_to_reg_in, mem_write_in, mem_read_in, r15_in,
               reg_write_in, mov_op_in, flush,
        input  operation, alu_result_out, alu_remainder_out, overflow_out,
               store_data_out, dest_reg_out, mem_to_reg_out, mem_write_out,
               mem_read_out, r15_out, reg_write_out, mov_op_out
    );

    modport slave (
        input  alu_op, funct, alu_src, rd1, rd2, imm, dest_reg,
               mem_to_reg_in, mem_write_in, mem_read_in, r15_in,
               reg_write_in, mov_op_in, flush,
        output operation, alu_result_out, alu_remainder_out, overflow_out,
               store_data_out, dest_reg_out, mem_to_reg_out, mem_write_out,
               mem_read_out, r15_out, reg_write_out, mov_op_out
    );

endinterface : ex_stage_if
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ex_alu                                                      |
// | Combinational operation decode and signed 16-bit ALU                 |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ex_alu
    import cpu_pkg::*;
(
    input  wire logic [1:0]    i_alu_op,
    input  wire logic [3:0]    i_funct,
    input  wire logic [DW-1:0] i_a,
    input  wire logic [DW-1:0] i_b,
    output logic      [3:0]    o_operation,
    output logic      [DW-1:0] o_result,
    output logic      [DW-1:0] o_remainder,
    output logic               o_overflow
);

    logic        [DW-1:0]   w_sum;
    logic        [DW-1:0]   w_diff;
    logic signed [DW-1:0]   w_sa;
    logic signed [DW-1:0]   w_sb;
    logic signed [DW-1:0]   w_div_b;
    logic signed [2*DW-1:0] w_prod;
    logic signed [DW-1:0]   w_quot;
    logic signed [DW-1:0]   w_rem;
    logic        [3:0]      w_amt;
    logic        [4:0]      w_inv_amt;
    logic                   w_div_zero;
    logic                   w_div_ovf;

    always_comb begin
        case (i_alu_op)
            ALUOP_ADD:   o_operation = OP_ADD;
            ALUOP_SUB:   o_operation = OP_SUB;
            ALUOP_RTYPE: o_operation = i_funct;
            default:     o_operation = OP_PASSB;
        endcase
    end

    assign w_sa       = i_a;
    assign w_sb       = i_b;
    assign w_sum      = i_a + i_b;
    assign w_diff     = i_a - i_b;
    assign w_prod     = w_sa * w_sb;
    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_a == 16'h8000) && (i_b == 16'hFFFF);
    // Substitute a harmless divisor so the divider never sees 0 or -32768/-1.
    assign w_div_b    = (w_div_zero || w_div_ovf) ? 16'sd1 : w_sb;
    assign w_quot     = w_sa / w_div_b;
    assign w_rem      = w_sa % w_div_b;
    assign w_amt      = i_b[3:0];
    assign w_inv_amt  = 5'd16 - {1'b0, w_amt};

    always_comb begin
        o_result    = '0;
        o_remainder = '0;
        o_overflow  = 1'b0;
        case (o_operation)
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_MUL: begin
                o_result    = w_prod[DW-1:0];
                o_remainder = w_prod[2*DW-1:DW];
                // Fits in 16 signed bits only if bits [31:15] are all copies of the sign.
                o_overflow  = !((&w_prod[2*DW-1:DW-1]) || !(|w_prod[2*DW-1:DW-1]));
            end
            OP_DIV: begin
                if (w_div_zero) begin
                    o_overflow = 1'b1;
                end else if (w_div_ovf) begin
                    o_result   = 16'h8000;
                    o_overflow = 1'b1;
                end else begin
                    o_result    = w_quot;
                    o_remainder = w_rem;
                end
            end
            OP_SLL:   o_result = i_a << w_amt;
            OP_SRL:   o_result = i_a >> w_amt;
            OP_ROL:   o_result = (i_a << w_amt) | (i_a >> w_inv_amt);
            OP_ROR:   o_result = (i_a >> w_amt) | (i_a << w_inv_amt);
            OP_PASSB: o_result = i_b;
            default: ;
        endcase
    end

endmodule : ex_alu
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ex_stage                                                    |
// | Execute stage: operand-B select, ALU and the EX/MEM register         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ex_stage
    import cpu_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    ex_stage_if.slave  bus
);

    logic [DW-1:0] w_b;
    logic [3:0]    w_operation;
    logic [DW-1:0] w_result;
    logic [DW-1:0] w_remainder;
    logic          w_overflow;

    assign w_b           = bus.alu_src ? bus.imm : bus.rd2;
    assign bus.operation = w_operation;

    ex_alu u_alu (
        .i_alu_op    (bus.alu_op),
        .i_funct     (bus.funct),
        .i_a         (bus.rd1),
        .i_b         (w_b),
        .o_operation (w_operation),
        .o_result    (w_result),
        .o_remainder (w_remainder),
        .o_overflow  (w_overflow)
    );

    logic [DW-1:0] r_result;
    logic [DW-1:0] r_remainder;
    logic          r_overflow;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_dest_reg;
    logic          r_mem_to_reg;
    logic          r_mem_write;
    logic          r_mem_read;
    logic          r_r15;
    logic          r_reg_write;
    logic          r_mov_op;

    // A flush still captures the data path; only side-effecting controls become a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result     <= '0;
            r_remainder  <= '0;
            r_overflow   <= 1'b0;
            r_store_data <= '0;
            r_dest_reg   <= '0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_r15        <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mov_op     <= 1'b0;
        end else begin
            r_result     <= w_result;
            r_remainder  <= w_remainder;
            r_store_data <= bus.rd1;
            r_dest_reg   <= bus.dest_reg;
            if (bus.flush) begin
                r_overflow   <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_r15        <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mov_op     <= 1'b0;
            end else begin
                r_overflow   <= w_overflow;
                r_mem_to_reg <= bus.mem_to_reg_in;
                r_mem_write  <= bus.mem_write_in;
                r_mem_read   <= bus.mem_read_in;
                r_r15        <= bus.r15_in;
                r_reg_write  <= bus.reg_write_in;
                r_mov_op     <= bus.mov_op_in;
            end
        end
    end

    assign bus.alu_result_out    = r_result;
    assign bus.alu_remainder_out = r_remainder;
    assign bus.overflow_out      = r_overflow;
    assign bus.store_data_out    = r_store_data;
    assign bus.dest_reg_out      = r_dest_reg;
    assign bus.mem_to_reg_out    = r_mem_to_reg;
    assign bus.mem_write_out     = r_mem_write;
    assign bus.mem_read_out      = r_mem_read;
    assign bus.r15_out           = r_r15;
    assign bus.reg_write_out     = r_reg_write;
    assign bus.mov_op_out        = r_mov_op;

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ex_stage                                                 |
// | Directed self-checking bench for the execute stage                   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ex_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_ctrl(input logic v);
        bus.mem_to_reg_in = v;
        bus.mem_write_in  = v;
        bus.mem_read_in   = v;
        bus.r15_in        = v;
        bus.reg_write_in  = v;
        bus.mov_op_in     = v;
    endtask

    task automatic check_ctrl(input string tag, input logic v);
        check({tag, ".mem_to_reg"}, {31'd0, bus.mem_to_reg_out}, {31'd0, v});
        check({tag, ".mem_write"},  {31'd0, bus.mem_write_out},  {31'd0, v});
        check({tag, ".mem_read"},   {31'd0, bus.mem_read_out},   {31'd0, v});
        check({tag, ".r15"},        {31'd0, bus.r15_out},        {31'd0, v});
        check({tag, ".reg_write"},  {31'd0, bus.reg_write_out},  {31'd0, v});
        check({tag, ".mov_op"},     {31'd0, bus.mov_op_out},     {31'd0, v});
    endtask

    // Drive one instruction, check the decode, clock it, check the EX/MEM outputs.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [3:0] fn,
                          input logic src, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] im, input logic [3:0] exp_op,
                          input logic [15:0] exp_res, input logic [15:0] exp_rem,
                          input logic exp_ovf);
        bus.alu_op  = aop;
        bus.funct   = fn;
        bus.alu_src = src;
        bus.rd1     = a;
        bus.rd2     = b;
        bus.imm     = im;
        #1;
        check({tag, ".op"}, {28'd0, bus.operation}, {28'd0, exp_op});
        @(posedge clk);
        #1;
        check({tag, ".res"},   {16'd0, bus.alu_result_out},    {16'd0, exp_res});
        check({tag, ".rem"},   {16'd0, bus.alu_remainder_out}, {16'd0, exp_rem});
        check({tag, ".ovf"},   {31'd0, bus.overflow_out},      {31'd0, exp_ovf});
        check({tag, ".store"}, {16'd0, bus.store_data_out},    {16'd0, a});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".res"},   {16'd0, bus.alu_result_out},    32'd0);
        check({tag, ".rem"},   {16'd0, bus.alu_remainder_out}, 32'd0);
        check({tag, ".ovf"},   {31'd0, bus.overflow_out},      32'd0);
        check({tag, ".store"}, {16'd0, bus.store_data_out},    32'd0);
        check({tag, ".dest"},  {28'd0, bus.dest_reg_out},      32'd0);
        check_ctrl(tag, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset        = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 4'b0000;
        bus.alu_src  = 1'b0;
        bus.rd1      = 16'h1111;
        bus.rd2      = 16'h2222;
        bus.imm      = 16'h3333;
        bus.dest_reg = 4'd9;
        bus.flush    = 1'b0;
        set_ctrl(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        reset = 1'b1;
        set_ctrl(1'b0);
        bus.dest_reg = 4'd3;

        run_op("add_ovf",   2'b10, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000, 16'h8000, 16'h0000, 1'b1);
        check("add_ovf.dest", {28'd0, bus.dest_reg_out}, 32'd3);
        run_op("sub",       2'b10, 4'b0001, 1'b0, 16'h0005, 16'h0002, 16'h0000, 4'b0001, 16'h0003, 16'h0000, 1'b0);
        run_op("sub_ovf",   2'b10, 4'b0001, 1'b0, 16'h8000, 16'h0001, 16'h0000, 4'b0001, 16'h7FFF, 16'h0000, 1'b1);
        run_op("and",       2'b10, 4'b0010, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 4'b0010, 16'h00F0, 16'h0000, 1'b0);
        run_op("or",        2'b10, 4'b0011, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 4'b0011, 16'hFFF0, 16'h0000, 1'b0);
        run_op("mul_big",   2'b10, 4'b0100, 1'b0, 16'h0100, 16'h0100, 16'h0000, 4'b0100, 16'h0000, 16'h0001, 1'b1);
        run_op("mul_neg",   2'b10, 4'b0100, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 4'b0100, 16'hFFFE, 16'hFFFF, 1'b0);
        run_op("div_neg",   2'b10, 4'b0101, 1'b0, 16'hFFF9, 16'h0002, 16'h0000, 4'b0101, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op("div_negb",  2'b10, 4'b0101, 1'b0, 16'h0007, 16'hFFFE, 16'h0000, 4'b0101, 16'hFFFD, 16'h0001, 1'b0);
        run_op("div_zero",  2'b10, 4'b0101, 1'b0, 16'h1234, 16'h0000, 16'h0000, 4'b0101, 16'h0000, 16'h0000, 1'b1);
        run_op("div_min",   2'b10, 4'b0101, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 4'b0101, 16'h8000, 16'h0000, 1'b1);
        run_op("ld_addr",   2'b00, 4'b1111, 1'b1, 16'h0010, 16'h7777, 16'hFFFC, 4'b0000, 16'h000C, 16'h0000, 1'b0);
        run_op("beq_cmp",   2'b01, 4'b0100, 1'b1, 16'h0005, 16'h7777, 16'h0005, 4'b0001, 16'h0000, 16'h0000, 1'b0);
        run_op("li",        2'b11, 4'b0000, 1'b1, 16'h5555, 16'h7777, 16'h1234, 4'b1111, 16'h1234, 16'h0000, 1'b0);
        run_op("rol",       2'b10, 4'b1010, 1'b0, 16'h8001, 16'h0001, 16'h0000, 4'b1010, 16'h0003, 16'h0000, 1'b0);
        run_op("ror",       2'b10, 4'b1011, 1'b0, 16'h8001, 16'h0001, 16'h0000, 4'b1011, 16'hC000, 16'h0000, 1'b0);
        run_op("srl",       2'b10, 4'b1001, 1'b0, 16'h8000, 16'h0004, 16'h0000, 4'b1001, 16'h0800, 16'h0000, 1'b0);
        run_op("sll15",     2'b10, 4'b1000, 1'b0, 16'h0001, 16'h000F, 16'h0000, 4'b1000, 16'h8000, 16'h0000, 1'b0);
        run_op("sll_amt0",  2'b10, 4'b1000, 1'b0, 16'h1234, 16'h0010, 16'h0000, 4'b1000, 16'h1234, 16'h0000, 1'b0);
        run_op("rol_amt0",  2'b10, 4'b1010, 1'b0, 16'hA5C3, 16'h0000, 16'h0000, 4'b1010, 16'hA5C3, 16'h0000, 1'b0);
        run_op("undef",     2'b10, 4'b1100, 1'b0, 16'h1234, 16'h0001, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 1'b0);

        // Bubble: controls and overflow squashed, data still captured.
        set_ctrl(1'b1);
        bus.dest_reg = 4'd5;
        bus.flush    = 1'b1;
        run_op("flush",     2'b10, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000, 16'h8000, 16'h0000, 1'b0);
        check("flush.dest", {28'd0, bus.dest_reg_out}, 32'd5);
        check_ctrl("flush", 1'b0);
        bus.flush = 1'b0;
        run_op("noflush",   2'b10, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000, 16'h8000, 16'h0000, 1'b1);
        check("noflush.dest", {28'd0, bus.dest_reg_out}, 32'd5);
        check_ctrl("noflush", 1'b1);

        // Asynchronous reset mid-run, away from any rising edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        reset        = 1'b1;
        bus.dest_reg = 4'd7;
        run_op("post_rst",  2'b10, 4'b0001, 1'b0, 16'h0042, 16'h0002, 16'h0000, 4'b0001, 16'h0040, 16'h0000, 1'b0);
        check("post_rst.dest", {28'd0, bus.dest_reg_out}, 32'd7);
        check_ctrl("post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ex_stage
`default_nettype wire
